// File: rtl/joust2_rom_arbiter.sv
// Program-ROM BRAM arbiter: HPS download stream, main CPU and sound CPU.
// Optional ROM_CHECKSUM_EN adds dl_sum/sum_valid (running byte sum of the download).
module joust2_rom_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] SND_BASE = 17'h10000,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_wait,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              snd_req,
  input  logic [15:0]       snd_addr,
  output logic              snd_ack,
  output logic [DATA_W-1:0] snd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              rom_ready,
  output logic              dl_overrun
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]       dl_sum,
  output logic              sum_valid
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        lat_cnt;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              rr_snd;
  logic              gnt_snd;
  logic              dl_active_q;
  logic              dl_seen;

  logic              dl_rise;
  logic              wr_go;
  logic              rd_go;
  logic              pick_snd;
  logic [ADDR_W-1:0] cpu_mem;
  logic [ADDR_W-1:0] snd_mem;

  assign dl_wait  = buf_full;
  assign dl_rise  = dl_active & ~dl_active_q;
  assign wr_go    = (state == S_IDLE) & buf_full;
  // No grant in the ack cycle: the requester still holds req there.
  assign rd_go    = (state == S_IDLE) & ~buf_full & ~dl_active
                  & ~cpu_ack & ~snd_ack & (cpu_req | snd_req);
  assign pick_snd = snd_req & (~cpu_req | rr_snd);
  assign cpu_mem  = {{(ADDR_W-16){1'b0}}, cpu_addr};
  assign snd_mem  = SND_BASE + {{(ADDR_W-16){1'b0}}, snd_addr};

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      rr_snd      <= 1'b0;
      gnt_snd     <= 1'b0;
      dl_active_q <= 1'b0;
      dl_seen     <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_data    <= '0;
      snd_ack     <= 1'b0;
      snd_data    <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_din     <= '0;
      rom_ready   <= 1'b0;
      dl_overrun  <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      cpu_ack     <= 1'b0;
      snd_ack     <= 1'b0;
      mem_we      <= 1'b0;
      if (dl_active) dl_seen <= 1'b1;

      if (dl_wr) begin
        if (buf_full) begin
          dl_overrun <= 1'b1;
        end else begin
          buf_full <= 1'b1;
          buf_addr <= dl_addr;
          buf_data <= dl_data;
        end
      end

      if (dl_rise)
        rom_ready <= 1'b0;
      else if (dl_seen && !dl_active && !buf_full && state == S_IDLE)
        rom_ready <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (wr_go) begin
            state    <= S_WRITE;
            mem_we   <= 1'b1;
            mem_addr <= buf_addr;
            mem_din  <= buf_data;
            buf_full <= 1'b0;
          end else if (rd_go) begin
            state    <= S_READ;
            lat_cnt  <= 2'(MEM_LAT - 1);
            gnt_snd  <= pick_snd;
            rr_snd   <= ~pick_snd;
            mem_addr <= pick_snd ? snd_mem : cpu_mem;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ: begin
          if (lat_cnt == 2'd0) state <= S_RESP;
          else lat_cnt <= lat_cnt - 2'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          if (gnt_snd) begin
            snd_data <= mem_dout;
            snd_ack  <= 1'b1;
          end else begin
            cpu_data <= mem_dout;
            cpu_ack  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_CHECKSUM_EN
  assign sum_valid = rom_ready;

  // Patch writes after the load leave the sum alone.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      dl_sum <= '0;
    else if (dl_rise)
      dl_sum <= '0;
    else if (wr_go && dl_active)
      dl_sum <= dl_sum + 16'(buf_data);
  end
`endif

endmodule

// File: tb/tb_joust2_rom_arbiter.sv
// Bench for joust2_rom_arbiter: table of per-cycle vectors plus
// hand sequences for arbitration, overrun, reset abort and checksum.
module tb_joust2_rom_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ack;
  logic [7:0]  cpu_data;
  logic        snd_req;
  logic [15:0] snd_addr;
  logic        snd_ack;
  logic [7:0]  snd_data;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        rom_ready;
  logic        dl_overrun;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] dl_sum;
  logic        sum_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  joust2_rom_arbiter dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ack   (cpu_ack),
    .cpu_data  (cpu_data),
    .snd_req   (snd_req),
    .snd_addr  (snd_addr),
    .snd_ack   (snd_ack),
    .snd_data  (snd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rom_ready (rom_ready),
    .dl_overrun(dl_overrun)
`ifdef ROM_CHECKSUM_EN
    ,
    .dl_sum    (dl_sum),
    .sum_valid (sum_valid)
`endif
  );

  // BRAM model, latency 1; preload applied while reset is held
  logic [7:0] mem [0:131071];
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      mem[17'h01234] <= 8'h3C;
      mem[17'h1FFFF] <= 8'h77;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic        act;
    logic        wr;
    logic [16:0] a;
    logic [7:0]  d;
    logic        creq;
    logic [15:0] ca;
    logic        we;
    logic [16:0] maddr;
    logic [7:0]  mdin;
    logic        wt;
    logic        cack;
    logic [7:0]  cdata;
    logic        rdy;
  } vec_t;

  vec_t tbl [0:10];

  function automatic vec_t mk(
    logic act, logic wr, logic [16:0] a, logic [7:0] d,
    logic creq, logic [15:0] ca,
    logic we, logic [16:0] maddr, logic [7:0] mdin,
    logic wt, logic cack, logic [7:0] cdata, logic rdy);
    vec_t v;
    v.act = act; v.wr = wr; v.a = a; v.d = d;
    v.creq = creq; v.ca = ca;
    v.we = we; v.maddr = maddr; v.mdin = mdin;
    v.wt = wt; v.cack = cack; v.cdata = cdata; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_addr = '0; snd_req = 1'b0; snd_addr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  int   ack_cyc [4];
  byte  ack_who [4];
  int   n_ack;
  logic [16:0] ma_k1, ma_k5;
  logic [7:0]  sd_seen, cd_seen;

  initial begin
    // download A5 @0x10, then a CPU read of 0x1234
    tbl[0]  = mk(1,0,17'h0,8'h0,  0,16'h0,    0,17'h0,8'h0,   0,0,8'h0,0);
    tbl[1]  = mk(1,1,17'h10,8'hA5,0,16'h0,    0,17'h0,8'h0,   0,0,8'h0,0);
    tbl[2]  = mk(1,0,17'h0,8'h0,  0,16'h0,    0,17'h0,8'h0,   1,0,8'h0,0);
    tbl[3]  = mk(1,0,17'h0,8'h0,  0,16'h0,    1,17'h10,8'hA5, 0,0,8'h0,0);
    tbl[4]  = mk(0,0,17'h0,8'h0,  0,16'h0,    0,17'h10,8'hA5, 0,0,8'h0,0);
    tbl[5]  = mk(0,0,17'h0,8'h0,  0,16'h0,    0,17'h10,8'hA5, 0,0,8'h0,1);
    tbl[6]  = mk(0,0,17'h0,8'h0,  1,16'h1234, 0,17'h10,8'hA5, 0,0,8'h0,1);
    tbl[7]  = mk(0,0,17'h0,8'h0,  1,16'h1234, 0,17'h1234,8'hA5,0,0,8'h0,1);
    tbl[8]  = mk(0,0,17'h0,8'h0,  1,16'h1234, 0,17'h1234,8'hA5,0,0,8'h0,1);
    tbl[9]  = mk(0,0,17'h0,8'h0,  1,16'h1234, 0,17'h1234,8'hA5,0,1,8'h3C,1);
    tbl[10] = mk(0,0,17'h0,8'h0,  0,16'h0,    0,17'h1234,8'hA5,0,0,8'h3C,1);

    do_reset();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_dl_wait", dl_wait, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_snd_ack", snd_ack, 0);
    chk("rst_snd_data", snd_data, 0);
    chk("rst_rom_ready", rom_ready, 0);
    chk("rst_overrun", dl_overrun, 0);

    for (int i = 0; i < 11; i++) begin
      dl_active = tbl[i].act; dl_wr = tbl[i].wr;
      dl_addr = tbl[i].a; dl_data = tbl[i].d;
      cpu_req = tbl[i].creq; cpu_addr = tbl[i].ca;
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d_mem_din", i), mem_din, tbl[i].mdin);
      chk($sformatf("v%0d_dl_wait", i), dl_wait, tbl[i].wt);
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, tbl[i].cack);
      chk($sformatf("v%0d_cpu_data", i), cpu_data, tbl[i].cdata);
      chk($sformatf("v%0d_snd_ack", i), snd_ack, 0);
      chk($sformatf("v%0d_rom_ready", i), rom_ready, tbl[i].rdy);
      chk($sformatf("v%0d_overrun", i), dl_overrun, 0);
      step();
    end

    // round robin with both requesters held
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    snd_req = 1'b1; snd_addr = 16'hFFFF;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      ack_cyc[i] = -1;
      ack_who[i] = "-";
    end
    sd_seen = '0; cd_seen = '0; ma_k1 = '0; ma_k5 = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) ma_k1 = mem_addr;
      if (k == 5) ma_k5 = mem_addr;
      if ((cpu_ack || snd_ack) && n_ack < 4) begin
        ack_cyc[n_ack] = k;
        ack_who[n_ack] = cpu_ack ? "C" : "S";
        n_ack++;
      end
      if (snd_ack) sd_seen = snd_data;
      if (cpu_ack) cd_seen = cpu_data;
      step();
    end
    cpu_req = 1'b0; snd_req = 1'b0;
    chk("rr_ack_count", n_ack, 4);
    chk("rr_ack0_cyc", ack_cyc[0], 3);
    chk("rr_ack1_cyc", ack_cyc[1], 7);
    chk("rr_ack2_cyc", ack_cyc[2], 11);
    chk("rr_ack3_cyc", ack_cyc[3], 15);
    chk("rr_ack0_who", ack_who[0], "C");
    chk("rr_ack1_who", ack_who[1], "S");
    chk("rr_ack2_who", ack_who[2], "C");
    chk("rr_ack3_who", ack_who[3], "S");
    chk("rr_cpu_addr", ma_k1, 17'h01234);
    chk("rr_snd_addr", ma_k5, 17'h1FFFF);
    chk("rr_cpu_data", cd_seen, 8'h3C);
    chk("rr_snd_data", sd_seen, 8'h77);
    step();

    // back-to-back dl_wr: second byte dropped
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 17'h20; dl_data = 8'h11;
    step();
    dl_addr = 17'h21; dl_data = 8'h22;
    chk("ovr_wait", dl_wait, 1);
    step();
    dl_wr = 1'b0;
    chk("ovr_we", mem_we, 1);
    chk("ovr_addr", mem_addr, 17'h20);
    chk("ovr_din", mem_din, 8'h11);
    chk("ovr_flag", dl_overrun, 1);
    step();
    chk("ovr_we_low", mem_we, 0);
    dl_active = 1'b0;
    step();
    step();
    chk("ovr_first_byte", mem[17'h20], 8'h11);
    chk("ovr_second_dropped", mem[17'h21] == 8'h22, 0);
    chk("ovr_rom_ready", rom_ready, 1);

    // reset while in READ aborts the read
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    step();
    chk("abort_in_read", mem_addr, 17'h01234);
    reset_n = 1'b0; cpu_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("abort_overrun_clr", dl_overrun, 0);
    chk("abort_rom_ready", rom_ready, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_no_ack%0d", k), cpu_ack, 0);
      step();
    end

`ifdef ROM_CHECKSUM_EN
    dl_active = 1'b1;
    for (int b = 0; b < 3; b++) begin
      dl_wr = 1'b1; dl_addr = 17'(17'h30 + b);
      dl_data = (b == 2) ? 8'h02 : 8'hFF;
      step();
      dl_wr = 1'b0;
      step();
      step();
    end
    dl_active = 1'b0;
    step();
    step();
    step();
    chk("sum_value", dl_sum, 16'h0200);
    chk("sum_valid", sum_valid, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
